// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: default 640x480@60 timing constants and sync polarity encodings
package vga_timing_gen_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} pol_e;
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: modulo-N counter with enable and a combinational wrap pulse
module vga_wrap_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);
  logic [W-1:0] r_count;
  assign o_count = r_count;
  assign o_wrap = i_en && (r_count == W'(N - 1));
  always_ff @(posedge Clock)
    if (!Reset) r_count <= '0;
    else if (i_en) r_count <= o_wrap ? '0 : r_count + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/coordinate generator; every output is registered one clock
// after the counter state it decodes, so decodes and pulses stay mutually aligned.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter pol_e H_POL    = POL_LOW,
  parameter pol_e V_POL    = POL_LOW,
  parameter int   CLK_DIV  = 2,
  parameter int   X_WIDTH  = 10,
  parameter int   Y_WIDTH  = 10
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iEnable,
  output logic [X_WIDTH-1:0] oVideoMemCol,
  output logic [Y_WIDTH-1:0] oVideoMemRow,
  output logic               oVGAHorizontalSync,
  output logic               oVGAVerticalSync,
  output logic               oDisplay,
  output logic               oPixelTick,
  output logic               oLineStart,
  output logic               oFrameStart,
  output logic [7:0]         oFrameCount
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [PW-1:0] r_presc;
  logic [X_WIDTH-1:0] w_h;
  logic [Y_WIDTH-1:0] w_v;
  logic w_tick, w_adv, w_h_wrap, w_v_wrap, w_disp, w_hs, w_vs;
  assign w_tick = r_presc == PW'(CLK_DIV - 1);
  assign w_adv = w_tick && iEnable;
  always_ff @(posedge Clock)
    if (!Reset) r_presc <= '0;
    else r_presc <= w_tick ? '0 : r_presc + PW'(1);
  vga_wrap_counter #(.N(H_TOTAL), .W(X_WIDTH)) u_hcnt (
    .Clock(Clock), .Reset(Reset), .i_en(w_adv), .o_count(w_h), .o_wrap(w_h_wrap)
  );
  vga_wrap_counter #(.N(V_TOTAL), .W(Y_WIDTH)) u_vcnt (
    .Clock(Clock), .Reset(Reset), .i_en(w_h_wrap), .o_count(w_v), .o_wrap(w_v_wrap)
  );
  always_comb begin
    w_disp = (w_h < X_WIDTH'(H_ACTIVE)) && (w_v < Y_WIDTH'(V_ACTIVE));
    w_hs = (w_h >= X_WIDTH'(H_ACTIVE + H_FP)) && (w_h < X_WIDTH'(H_ACTIVE + H_FP + H_SYNC));
    w_vs = (w_v >= Y_WIDTH'(V_ACTIVE + V_FP)) && (w_v < Y_WIDTH'(V_ACTIVE + V_FP + V_SYNC));
  end
  always_ff @(posedge Clock)
    if (!Reset) begin
      oVideoMemCol <= '0;
      oVideoMemRow <= '0;
      oDisplay <= 1'b0;
      oVGAHorizontalSync <= ~logic'(H_POL);
      oVGAVerticalSync <= ~logic'(V_POL);
      oPixelTick <= 1'b0;
      oLineStart <= 1'b0;
      oFrameStart <= 1'b0;
      oFrameCount <= '0;
    end else begin
      oVideoMemCol <= w_disp ? w_h : '0;
      oVideoMemRow <= w_disp ? w_v : '0;
      oDisplay <= w_disp;
      oVGAHorizontalSync <= w_hs ? logic'(H_POL) : ~logic'(H_POL);
      oVGAVerticalSync <= w_vs ? logic'(V_POL) : ~logic'(V_POL);
      oPixelTick <= w_adv;
      oLineStart <= w_adv && (w_h == '0);
      oFrameStart <= w_adv && (w_h == '0) && (w_v == '0);
      if (w_v_wrap) oFrameCount <= oFrameCount + 8'd1;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default-timing instance and a tiny overridden instance
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic d_rst, d_en, d_hs, d_vs, d_disp, d_tick, d_line, d_frame;
  logic [9:0] d_col, d_row;
  logic [7:0] d_fc;
  logic s_rst, s_en, s_hs, s_vs, s_disp, s_tick, s_line, s_frame;
  logic [3:0] s_col;
  logic [2:0] s_row;
  logic [7:0] s_fc;
  int n_tests = 0, n_fail = 0;

  vga_timing_gen dut (
    .Clock(clk), .Reset(d_rst), .iEnable(d_en), .oVideoMemCol(d_col), .oVideoMemRow(d_row),
    .oVGAHorizontalSync(d_hs), .oVGAVerticalSync(d_vs), .oDisplay(d_disp), .oPixelTick(d_tick),
    .oLineStart(d_line), .oFrameStart(d_frame), .oFrameCount(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(POL_HIGH), .CLK_DIV(1), .X_WIDTH(4), .Y_WIDTH(3)
  ) dut_s (
    .Clock(clk), .Reset(s_rst), .iEnable(s_en), .oVideoMemCol(s_col), .oVideoMemRow(s_row),
    .oVGAHorizontalSync(s_hs), .oVGAVerticalSync(s_vs), .oDisplay(s_disp), .oPixelTick(s_tick),
    .oLineStart(s_line), .oFrameStart(s_frame), .oFrameCount(s_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic d_walk_line(input int ln);
    int px = 0, hs_low = 0, hs_first = -1, vs_low = 0, last = 0, bad_gap = 0, clks = 0;
    bit done = 0;
    while (!done && clks < 2000) begin
      @(negedge clk);
      clks++;
      if (!d_vs) vs_low++;
      if (d_tick) begin
        if (clks - last != 2) bad_gap++;
        last = clks;
        px++;
        if (d_line) done = 1;
        else begin
          if (!d_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = px;
          end
          if (px == 639) begin
            chk("d_col_639", 32'(d_col), 639);
            chk("d_row_act", 32'(d_row), 32'(ln));
            chk("d_disp_639", 32'(d_disp), 1);
          end
          if (px == 640) begin
            chk("d_col_640", 32'(d_col), 0);
            chk("d_disp_640", 32'(d_disp), 0);
          end
        end
      end
    end
    chk("d_line_len", 32'(px), 800);
    chk("d_hs_low_ticks", 32'(hs_low), 96);
    chk("d_hs_first_col", 32'(hs_first), 656);
    chk("d_vs_low", 32'(vs_low), 0);
    chk("d_tick_gap", 32'(bad_gap), 0);
  endtask

  initial begin
    d_rst = 0; d_en = 1; s_rst = 0; s_en = 1;
    repeat (3) @(negedge clk);
    chk("d_rst_col", 32'(d_col), 0);
    chk("d_rst_row", 32'(d_row), 0);
    chk("d_rst_disp", 32'(d_disp), 0);
    chk("d_rst_hs", 32'(d_hs), 1);
    chk("d_rst_vs", 32'(d_vs), 1);
    chk("d_rst_pulses", 32'({d_tick, d_line, d_frame}), 0);
    chk("d_rst_fc", 32'(d_fc), 0);
    chk("s_rst_hs", 32'(s_hs), 0);
    chk("s_rst_vs", 32'(s_vs), 1);
    chk("s_rst_pulses", 32'({s_tick, s_line, s_frame}), 0);
    d_rst = 1;
    @(negedge clk);
    chk("d_first_tick_early", 32'(d_tick), 0);
    @(negedge clk);
    chk("d_first_tick", 32'({d_tick, d_line, d_frame}), 7);
    chk("d_first_pos", 32'({d_row, d_col, d_disp}), 1);
    d_walk_line(0);
    d_walk_line(1);
    begin
      int clks = 0, pulses = 0, bad = 0;
      while (d_col != 10'd300 && clks < 1000) begin @(negedge clk); clks++; end
      chk("d_reach_300", 32'(d_col), 300);
      d_en = 0;
      repeat (50) begin
        @(negedge clk);
        if (d_tick || d_line || d_frame) pulses++;
        if (d_col != 10'd300) bad++;
      end
      chk("d_pause_pulses", 32'(pulses), 0);
      chk("d_pause_col_moved", 32'(bad), 0);
      d_en = 1;
      clks = 0;
      while (d_col == 10'd300 && clks < 10) begin @(negedge clk); clks++; end
      chk("d_resume_col", 32'(d_col), 301);
    end
    begin
      int clks = 0;
      while (!(d_row == 10'd3 && d_col == 10'd400) && clks < 8000) begin @(negedge clk); clks++; end
      chk("d_reach_3_400", 32'({d_row, d_col}), 32'({10'd3, 10'd400}));
      d_rst = 0;
      @(negedge clk);
      chk("d_mid_rst_pos", 32'({d_row, d_col, d_disp}), 0);
      chk("d_mid_rst_sync", 32'({d_hs, d_vs}), 3);
      chk("d_mid_rst_pulses", 32'({d_tick, d_line, d_frame}), 0);
      d_rst = 1;
      @(negedge clk);
      chk("d_mid_rel_early", 32'(d_tick), 0);
      @(negedge clk);
      chk("d_mid_rel_tick", 32'({d_tick, d_line, d_frame}), 7);
      chk("d_mid_rel_pos", 32'({d_row, d_col}), 0);
    end
    s_rst = 1;
    begin
      int px = 0, ln = 0, e_hs = 0, e_vs = 0, e_disp = 0, e_pos = 0, e_pulse = 0, n_line = 0;
      for (int i = 0; i < 84; i++) begin
        @(negedge clk);
        if (s_hs != (px == 9 || px == 10)) e_hs++;
        if (s_vs != (ln != 5)) e_vs++;
        if (s_disp != (px < 8 && ln < 4)) e_disp++;
        if (s_col != ((px < 8 && ln < 4) ? 4'(px) : 4'd0)) e_pos++;
        if (s_row != ((px < 8 && ln < 4) ? 3'(ln) : 3'd0)) e_pos++;
        if (!s_tick || s_line != (px == 0) || s_frame != (i == 0)) e_pulse++;
        if (s_line) n_line++;
        px = px == 11 ? 0 : px + 1;
        if (px == 0) ln++;
      end
      chk("s_hs_cols_9_10", 32'(e_hs), 0);
      chk("s_vs_line5", 32'(e_vs), 0);
      chk("s_disp", 32'(e_disp), 0);
      chk("s_coords", 32'(e_pos), 0);
      chk("s_pulses", 32'(e_pulse), 0);
      chk("s_lines_per_frame", 32'(n_line), 7);
      @(negedge clk);
      chk("s_frame_len_84", 32'({s_frame, s_line}), 3);
      chk("s_fc_1", 32'(s_fc), 1);
    end
    begin
      int k = 1, clks = 0, fc255 = -1;
      while (k < 256 && clks < 25000) begin
        @(negedge clk);
        clks++;
        if (s_frame) begin
          k++;
          if (k == 255) fc255 = 32'(s_fc);
        end
      end
      chk("s_frames", 32'(k), 256);
      chk("s_fc_255", 32'(fc255), 255);
      chk("s_fc_wrap", 32'(s_fc), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync and back porch, in lines.
REQ-005 Parameters H_POL / V_POL, default 0 / 0, sync active level (0 = active-low).
REQ-006 Parameter CLK_DIV, default 2, number of Clock cycles per pixel; legal values 1 to 16.
REQ-007 Parameters X_WIDTH / Y_WIDTH, default 10 / 10, counter and coordinate widths; each SHALL hold H_TOTAL-1 / V_TOTAL-1.
REQ-008 Port Clock, input, 1 bit, the only clock.
REQ-009 Port Reset, input, 1 bit, synchronous, active-low.
REQ-010 Port iEnable, input, 1 bit, counters advance only while this is high.
REQ-011 Ports oVideoMemCol / oVideoMemRow, outputs, X_WIDTH / Y_WIDTH bits, pixel coordinate; 0 outside the active area.
REQ-012 Ports oVGAHorizontalSync / oVGAVerticalSync, outputs, 1 bit each, sync signals at the parameterised polarity.
REQ-013 Port oDisplay, output, 1 bit, high while in the active area.
REQ-014 Ports oPixelTick / oLineStart / oFrameStart, outputs, 1 bit each, single-Clock pulses.
REQ-015 Port oFrameCount, output, 8 bits, free-running frame counter.

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way for the vertical parameters.
REQ-017 The prescaler SHALL count 0..CLK_DIV-1; the internal tick fires when the prescaler is at CLK_DIV-1; with CLK_DIV=1 the tick fires every cycle.
REQ-018 The prescaler SHALL run regardless of iEnable.
REQ-019 On tick with iEnable=1, hCount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCount SHALL increment.
REQ-020 vCount SHALL wrap to 0 at V_TOTAL-1, and oFrameCount SHALL then increment, wrapping from 255 to 0.
REQ-021 With iEnable=0, the counters and all registered outputs SHALL hold their values; pulse outputs SHALL stay 0.
REQ-022 Horizontal sync SHALL be active for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-023 Vertical sync SHALL be active for vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-024 oDisplay SHALL be 1 iff hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-025 All outputs SHALL be registered, and all decodes SHALL appear exactly one Clock after the counter state they decode, mutually aligned.
REQ-026 oPixelTick SHALL be the tick gated by iEnable, delayed to the same alignment as the decodes.
REQ-027 oLineStart SHALL pulse for one Clock when hCount becomes 0.
REQ-028 oFrameStart SHALL pulse for one Clock when hCount and vCount both become 0; oLineStart SHALL also pulse on that cycle.
REQ-029 oVideoMemCol / oVideoMemRow SHALL equal hCount / vCount while oDisplay=1, and 0 otherwise.

Reset
REQ-030 When Reset=0 at a Clock edge, the prescaler, hCount, vCount, oFrameCount, coordinates, oDisplay and the pulses SHALL be set to 0.
REQ-031 During reset, the sync outputs SHALL be driven to their inactive level (~H_POL, ~V_POL).
REQ-032 Reset applied mid-line or mid-frame SHALL take effect on that edge, with no partial pulse emitted.
REQ-033 After Reset is released, the first tick SHALL occur CLK_DIV cycles later and SHALL decode hCount=0, vCount=0.

Structure
REQ-034 Default 640x480@60 timing constants and the sync polarity encodings SHALL live in the shared definitions include file.
REQ-035 One sub-module, vga_wrap_counter, SHALL be used: a parametrised modulo-N counter with enable, wrap pulse and synchronous active-low reset, instantiated twice (horizontal and vertical).
REQ-036 The prescaler SHALL be inline logic.

Verification
REQ-037 Defaults, iEnable=1: oPixelTick every 2 Clocks; 800 pixel ticks between oLineStart pulses; 525 lines between oFrameStart pulses.
REQ-038 Defaults: oVGAHorizontalSync low for exactly 96 ticks starting at column 656; oVGAVerticalSync low on lines 490–491 only.
REQ-039 At column 639, row 479: oDisplay=1 and coordinates are 639/479; on the next tick oDisplay=0 and coordinates are 0/0.
REQ-040 iEnable dropped for 50 Clocks at column 300: coordinates hold at 300, no pulses occur, and counting resumes at 301.
REQ-041 Reset=0 asserted at line 200, column 400: on the next Clock all outputs are at reset values with syncs high; after release the first frame starts at 0,0.
REQ-042 Overrides H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP/V_SYNC/V_BP=1, H_POL=1, CLK_DIV=1: line length 12 ticks, hsync high on columns 9–10, frame length 84 ticks, oFrameCount wraps after 256 frames.
